// File: rtl/seq_alu_pkg.sv
// Shared encodings for the sequential ALU: operator codes, zero-flag values,
// FSM states and the multiply/divide core mode.
package seq_alu_pkg;

  localparam logic [4:0] ALU_OPERATOR_ADD    = 5'h00;
  localparam logic [4:0] ALU_OPERATOR_SUB    = 5'h01;
  localparam logic [4:0] ALU_OPERATOR_SLL    = 5'h02;
  localparam logic [4:0] ALU_OPERATOR_SLT    = 5'h03;
  localparam logic [4:0] ALU_OPERATOR_SLTU   = 5'h04;
  localparam logic [4:0] ALU_OPERATOR_XOR    = 5'h05;
  localparam logic [4:0] ALU_OPERATOR_SRL    = 5'h06;
  localparam logic [4:0] ALU_OPERATOR_SRA    = 5'h07;
  localparam logic [4:0] ALU_OPERATOR_OR     = 5'h08;
  localparam logic [4:0] ALU_OPERATOR_AND    = 5'h09;
  localparam logic [4:0] ALU_OPERATOR_MUL    = 5'h0A;
  localparam logic [4:0] ALU_OPERATOR_MULH   = 5'h0B;
  localparam logic [4:0] ALU_OPERATOR_MULHSU = 5'h0C;
  localparam logic [4:0] ALU_OPERATOR_MULHU  = 5'h0D;
  localparam logic [4:0] ALU_OPERATOR_DIV    = 5'h0E;
  localparam logic [4:0] ALU_OPERATOR_DIVU   = 5'h0F;
  localparam logic [4:0] ALU_OPERATOR_REM    = 5'h10;
  localparam logic [4:0] ALU_OPERATOR_REMU   = 5'h11;

  localparam logic ALU_RESULT_IS_ZERO     = 1'b1;
  localparam logic ALU_RESULT_IS_NOT_ZERO = 1'b0;

  typedef enum logic [1:0] {
    SEQ_ALU_STATE_IDLE = 2'd0,
    SEQ_ALU_STATE_BUSY = 2'd1,
    SEQ_ALU_STATE_DONE = 2'd2
  } seq_alu_state_e;

  // What the iterative core should deliver once its bit loop finishes.
  typedef enum logic [1:0] {
    MD_MUL_LO = 2'd0,
    MD_MUL_HI = 2'd1,
    MD_DIV    = 2'd2,
    MD_REM    = 2'd3
  } md_mode_e;

  // True for operators that go through the multi-cycle multiply/divide core.
  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= ALU_OPERATOR_MUL) && (op <= ALU_OPERATOR_REMU);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv_core.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring divide
// on operand magnitudes, one bit per cycle, with sign fix-up on the way out.
// The first bit step happens on the start edge, so the result is ready
// (done high) during the XLEN-th cycle after start.
module seq_alu_muldiv_core
  import seq_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  md_mode_e        mode,
  input  logic            signed_a,
  input  logic            signed_b,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  logic [CNT_W-1:0] cnt;
  logic             running;
  logic             fin;
  md_mode_e         mode_q;
  logic             neg_q;
  logic             neg_rem;
  logic             div0;
  logic [XLEN-1:0]  acc_hi;
  logic [XLEN-1:0]  acc_lo;
  logic [XLEN-1:0]  mcand;

  logic             a_neg, b_neg;
  logic [XLEN-1:0]  mag_a, mag_b;
  logic [XLEN-1:0]  src_hi, src_lo, src_d;
  logic             src_div;
  logic [XLEN-1:0]  nxt_hi, nxt_lo;
  logic [XLEN:0]    shifted;
  logic [XLEN-1:0]  diff;
  logic [XLEN:0]    sum;

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign a_neg = signed_a & operand1[XLEN-1];
  assign b_neg = signed_b & operand2[XLEN-1];
  assign mag_a = a_neg ? -operand1 : operand1;
  assign mag_b = b_neg ? -operand2 : operand2;

  // One bit step, fed from the fresh operands on start or the accumulators afterwards.
  always_comb begin
    src_hi  = start ? '0    : acc_hi;
    src_lo  = start ? mag_a : acc_lo;
    src_d   = start ? mag_b : mcand;
    src_div = start ? (mode == MD_DIV || mode == MD_REM)
                    : (mode_q == MD_DIV || mode_q == MD_REM);
    nxt_hi  = src_hi;
    nxt_lo  = src_lo;
    shifted = {src_hi, src_lo[XLEN-1]};
    diff    = shifted[XLEN-1:0] - src_d;
    sum     = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_d} : '0);
    if (src_div) begin
      // Restoring divide: remainder in acc_hi, quotient shifts into acc_lo.
      if (shifted >= {1'b0, src_d}) begin
        nxt_hi = diff;
        nxt_lo = {src_lo[XLEN-2:0], 1'b1};
      end else begin
        nxt_hi = shifted[XLEN-1:0];
        nxt_lo = {src_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      // Shift-add multiply: {acc_hi, acc_lo} becomes the 2*XLEN product.
      nxt_hi = sum[XLEN:1];
      nxt_lo = {sum[0], src_lo[XLEN-1:1]};
    end
  end

  // Latch operands/signs on start, then iterate until XLEN steps are done.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      running <= 1'b0;
      fin     <= 1'b0;
      mode_q  <= MD_MUL_LO;
      neg_q   <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      mcand   <= '0;
    end else if (start) begin
      acc_hi  <= nxt_hi;
      acc_lo  <= nxt_lo;
      mcand   <= mag_b;
      mode_q  <= mode;
      neg_q   <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      div0    <= (operand2 == '0);
      cnt     <= CNT_W'(1);
      running <= 1'b1;
      fin     <= 1'b0;
    end else if (running) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
      if (cnt == CNT_W'(XLEN - 1)) begin
        running <= 1'b0;
        fin     <= 1'b1;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      fin <= 1'b0;
    end
  end

  // Sign fix-up and result selection; divide-by-zero quotient is forced to all ones.
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -acc_lo : acc_lo;
    rem_fix  = neg_rem ? -acc_hi : acc_hi;
    case (mode_q)
      MD_MUL_LO: result = prod_fix[XLEN-1:0];
      MD_MUL_HI: result = prod_fix[2*XLEN-1:XLEN];
      MD_DIV:    result = div0 ? '1 : quo_fix;
      MD_REM:    result = rem_fix;
      default:   result = '0;
    endcase
  end

  assign done = fin;

endmodule

// File: rtl/seq_alu.sv
// Sequential execute-stage ALU: single-cycle base ops, iterative RV-M ops,
// valid/ready on both sides with the result held until accepted.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      operator,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            result_is_zero,
  output logic            illegal_op
);

  seq_alu_state_e state, state_next;

  logic [XLEN-1:0]        res_p1;
  logic                   illegal_p1;
  logic [XLEN-1:0]        simple_res;
  logic                   simple_ill;
  logic                   op_is_md;
  logic                   md_start, md_done;
  logic                   md_signed_a, md_signed_b;
  md_mode_e               md_mode;
  logic [XLEN-1:0]        md_result;
  logic [SHAMT_W-1:0]     shamt;
  logic signed [XLEN-1:0] op1_s, op2_s;

  assign op_is_md       = is_muldiv(operator);
  assign shamt          = operand2[SHAMT_W-1:0];
  assign op1_s          = operand1;
  assign op2_s          = operand2;
  assign in_ready       = (state == SEQ_ALU_STATE_IDLE);
  assign out_valid      = (state == SEQ_ALU_STATE_DONE);
  assign result         = res_p1;
  assign result_is_zero = (res_p1 == '0) ? ALU_RESULT_IS_ZERO : ALU_RESULT_IS_NOT_ZERO;
  assign illegal_op     = illegal_p1;

  // Single-cycle operations; anything unrecognised yields zero and the illegal flag.
  always_comb begin
    simple_res = '0;
    simple_ill = 1'b0;
    case (operator)
      ALU_OPERATOR_ADD:  simple_res = operand1 + operand2;
      ALU_OPERATOR_SUB:  simple_res = operand1 - operand2;
      ALU_OPERATOR_SLL:  simple_res = operand1 << shamt;
      ALU_OPERATOR_SLT:  simple_res = {{(XLEN-1){1'b0}}, (op1_s < op2_s)};
      ALU_OPERATOR_SLTU: simple_res = {{(XLEN-1){1'b0}}, (operand1 < operand2)};
      ALU_OPERATOR_XOR:  simple_res = operand1 ^ operand2;
      ALU_OPERATOR_SRL:  simple_res = operand1 >> shamt;
      ALU_OPERATOR_SRA:  simple_res = op1_s >>> shamt;
      ALU_OPERATOR_OR:   simple_res = operand1 | operand2;
      ALU_OPERATOR_AND:  simple_res = operand1 & operand2;
      default:           simple_ill = 1'b1;
    endcase
  end

  // Map RV-M operators onto core mode and operand signedness.
  always_comb begin
    md_mode     = MD_MUL_LO;
    md_signed_a = 1'b0;
    md_signed_b = 1'b0;
    case (operator)
      ALU_OPERATOR_MULH:   begin md_mode = MD_MUL_HI; md_signed_a = 1'b1; md_signed_b = 1'b1; end
      ALU_OPERATOR_MULHSU: begin md_mode = MD_MUL_HI; md_signed_a = 1'b1; end
      ALU_OPERATOR_MULHU:  md_mode = MD_MUL_HI;
      ALU_OPERATOR_DIV:    begin md_mode = MD_DIV; md_signed_a = 1'b1; md_signed_b = 1'b1; end
      ALU_OPERATOR_DIVU:   md_mode = MD_DIV;
      ALU_OPERATOR_REM:    begin md_mode = MD_REM; md_signed_a = 1'b1; md_signed_b = 1'b1; end
      ALU_OPERATOR_REMU:   md_mode = MD_REM;
      default:             md_mode = MD_MUL_LO;
    endcase
  end

  // Next-state logic and core start pulse.
  always_comb begin
    state_next = state;
    md_start   = 1'b0;
    case (state)
      SEQ_ALU_STATE_IDLE: begin
        if (in_valid) begin
          if (op_is_md) begin
            state_next = SEQ_ALU_STATE_BUSY;
            md_start   = 1'b1;
          end else begin
            state_next = SEQ_ALU_STATE_DONE;
          end
        end
      end
      SEQ_ALU_STATE_BUSY: if (md_done) state_next = SEQ_ALU_STATE_DONE;
      SEQ_ALU_STATE_DONE: if (out_ready) state_next = SEQ_ALU_STATE_IDLE;
      default:            state_next = SEQ_ALU_STATE_IDLE;
    endcase
  end

  // State register and result/flag register; loaded only on simple accept or core done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEQ_ALU_STATE_IDLE;
      res_p1     <= '0;
      illegal_p1 <= 1'b0;
    end else begin
      state <= state_next;
      if (state == SEQ_ALU_STATE_IDLE && in_valid && !op_is_md) begin
        res_p1     <= simple_res;
        illegal_p1 <= simple_ill;
      end else if (state == SEQ_ALU_STATE_BUSY && md_done) begin
        res_p1     <= md_result;
        illegal_p1 <= 1'b0;
      end
    end
  end

  seq_alu_muldiv_core #(
    .XLEN(XLEN)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .start    (md_start),
    .mode     (md_mode),
    .signed_a (md_signed_a),
    .signed_b (md_signed_b),
    .operand1 (operand1),
    .operand2 (operand2),
    .done     (md_done),
    .result   (md_result)
  );

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (XLEN=32): directed corners plus random
// operations checked through an expected-result queue.
module tb_seq_alu;
  import seq_alu_pkg::*;

  typedef struct packed {
    logic        ill;
    logic [31:0] res;
  } exp_t;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
    logic [31:0] res;
  } vec_t;

  localparam logic [4:0] SIMPLE_OPS [10] = '{ALU_OPERATOR_ADD, ALU_OPERATOR_SUB,
    ALU_OPERATOR_SLL, ALU_OPERATOR_SLT, ALU_OPERATOR_SLTU, ALU_OPERATOR_XOR,
    ALU_OPERATOR_SRL, ALU_OPERATOR_SRA, ALU_OPERATOR_OR, ALU_OPERATOR_AND};
  localparam logic [4:0] MD_OPS [8] = '{ALU_OPERATOR_MUL, ALU_OPERATOR_MULH,
    ALU_OPERATOR_MULHSU, ALU_OPERATOR_MULHU, ALU_OPERATOR_DIV, ALU_OPERATOR_DIVU,
    ALU_OPERATOR_REM, ALU_OPERATOR_REMU};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  operator;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        result_is_zero;
  logic        illegal_op;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  seq_alu #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .operator       (operator),
    .operand1       (operand1),
    .operand2       (operand2),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .result         (result),
    .result_is_zero (result_is_zero),
    .illegal_op     (illegal_op)
  );

  always #5 clk = ~clk;

  // Reference model in wide integer arithmetic; returns {illegal, result}.
  function automatic logic [32:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb2, sp;
    logic [63:0] up;
    logic [31:0] r;
    logic        ill;
    sa  = {{32{a[31]}}, a};
    sb2 = {{32{b[31]}}, b};
    r   = '0;
    ill = 1'b0;
    case (op)
      ALU_OPERATOR_ADD:    r = a + b;
      ALU_OPERATOR_SUB:    r = a - b;
      ALU_OPERATOR_SLL:    r = a << b[4:0];
      ALU_OPERATOR_SLT:    r = {31'b0, ($signed(a) < $signed(b))};
      ALU_OPERATOR_SLTU:   r = {31'b0, (a < b)};
      ALU_OPERATOR_XOR:    r = a ^ b;
      ALU_OPERATOR_SRL:    r = a >> b[4:0];
      ALU_OPERATOR_SRA:    r = $signed(a) >>> b[4:0];
      ALU_OPERATOR_OR:     r = a | b;
      ALU_OPERATOR_AND:    r = a & b;
      ALU_OPERATOR_MUL:    begin sp = sa * sb2; r = sp[31:0]; end
      ALU_OPERATOR_MULH:   begin sp = sa * sb2; r = sp[63:32]; end
      ALU_OPERATOR_MULHSU: begin sp = sa * $signed({32'b0, b}); r = sp[63:32]; end
      ALU_OPERATOR_MULHU:  begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
      ALU_OPERATOR_DIV: begin
        if (b == 0) r = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = $signed(a) / $signed(b);
      end
      ALU_OPERATOR_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_OPERATOR_REM: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else r = $signed(a) % $signed(b);
      end
      ALU_OPERATOR_REMU:   r = (b == 0) ? a : a % b;
      default:             ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  // Present one op (called just after a clock edge while IDLE); record its expectation.
  task automatic issue(input vec_t v);
    in_valid = 1'b1;
    operator = v.op;
    operand1 = v.a;
    operand2 = v.b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    operand1 = ~v.a;
    operand2 = ~v.b;
    sb.push_back('{v.ill, v.res});
  endtask

  // Edges since acceptance until out_valid (1 = next cycle); -1 if it never came.
  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (out_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result); end
    n_cmp++; if (result_is_zero !== ALU_RESULT_IS_ZERO) begin n_bad++; $display("FAIL reset_zero: got %b want %b", result_is_zero, ALU_RESULT_IS_ZERO); end
    n_cmp++; if (illegal_op !== 1'b0) begin n_bad++; $display("FAIL reset_illegal: got %b want 0", illegal_op); end
    rst = 1'b0;
  endtask

  // Runs a list of ops at full throughput and checks latency, result and flags.
  task automatic run_list(input string name, input vec_t v[$], input int want_lat);
    int   lat;
    exp_t e;
    foreach (v[i]) begin
      issue(v[i]);
      wait_out(lat);
      n_cmp++; if (lat != want_lat) begin n_bad++; $display("FAIL %s_lat[%0d] op=%h: got %0d want %0d", name, i, v[i].op, lat, want_lat); end
      e = sb.pop_front();
      n_cmp++; if (result !== e.res) begin n_bad++; $display("FAIL %s_result[%0d] op=%h a=%h b=%h: got %h want %h", name, i, v[i].op, v[i].a, v[i].b, result, e.res); end
      n_cmp++; if (result_is_zero !== ((e.res == 0) ? ALU_RESULT_IS_ZERO : ALU_RESULT_IS_NOT_ZERO)) begin n_bad++; $display("FAIL %s_zero[%0d]: got %b for result %h", name, i, result_is_zero, e.res); end
      n_cmp++; if (illegal_op !== e.ill) begin n_bad++; $display("FAIL %s_illegal[%0d]: got %b want %b", name, i, illegal_op, e.ill); end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL %s_release[%0d]: out_valid=%b in_ready=%b want 0/1", name, i, out_valid, in_ready); end
    end
  endtask

  task automatic test_simple();
    vec_t v[$];
    vec_t r;
    v.push_back('{ALU_OPERATOR_ADD,  32'd5,          32'd7,          1'b0, 32'd12});
    v.push_back('{ALU_OPERATOR_SUB,  32'd3,          32'd3,          1'b0, 32'd0});
    v.push_back('{ALU_OPERATOR_SRA,  32'h8000_0000,  32'h0000_0021,  1'b0, 32'hC000_0000});
    v.push_back('{ALU_OPERATOR_SLT,  32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 32'h1});
    v.push_back('{ALU_OPERATOR_SLTU, 32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 32'h0});
    v.push_back('{ALU_OPERATOR_SLL,  32'h0000_0003,  32'hFFFF_FFE4,  1'b0, 32'h0000_0030});
    v.push_back('{ALU_OPERATOR_AND,  32'hF0F0_1234,  32'h0FF0_FF00,  1'b0, 32'h00F0_1200});
    for (int i = 0; i < 12; i++) begin
      r.op = SIMPLE_OPS[$urandom_range(0, 9)];
      r.a  = $urandom;
      r.b  = $urandom;
      {r.ill, r.res} = ref_alu(r.op, r.a, r.b);
      v.push_back(r);
    end
    run_list("simple", v, 1);
  endtask

  task automatic test_mul();
    vec_t v[$];
    vec_t r;
    v.push_back('{ALU_OPERATOR_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000});
    v.push_back('{ALU_OPERATOR_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE});
    v.push_back('{ALU_OPERATOR_MUL,    32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0000});
    v.push_back('{ALU_OPERATOR_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF});
    v.push_back('{ALU_OPERATOR_MUL,    32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 32'hFFFF_FFEB});
    for (int i = 0; i < 8; i++) begin
      r.op = MD_OPS[$urandom_range(0, 3)];
      r.a  = $urandom;
      r.b  = $urandom;
      {r.ill, r.res} = ref_alu(r.op, r.a, r.b);
      v.push_back(r);
    end
    run_list("mul", v, 33);
  endtask

  task automatic test_div();
    vec_t v[$];
    vec_t r;
    v.push_back('{ALU_OPERATOR_DIV,  32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFD});
    v.push_back('{ALU_OPERATOR_REM,  32'hFFFF_FFF9, 32'd2,         1'b0, 32'hFFFF_FFFF});
    v.push_back('{ALU_OPERATOR_DIVU, 32'h1234_5678, 32'd0,         1'b0, 32'hFFFF_FFFF});
    v.push_back('{ALU_OPERATOR_DIV,  32'hFFFF_FFF9, 32'd0,         1'b0, 32'hFFFF_FFFF});
    v.push_back('{ALU_OPERATOR_REM,  32'd9,         32'd0,         1'b0, 32'd9});
    v.push_back('{ALU_OPERATOR_REMU, 32'hFFFF_FFF0, 32'd0,         1'b0, 32'hFFFF_FFF0});
    v.push_back('{ALU_OPERATOR_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000});
    v.push_back('{ALU_OPERATOR_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000});
    v.push_back('{ALU_OPERATOR_DIVU, 32'hFFFF_FFFF, 32'd16,        1'b0, 32'h0FFF_FFFF});
    for (int i = 0; i < 8; i++) begin
      r.op = MD_OPS[$urandom_range(4, 7)];
      r.a  = $urandom;
      r.b  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)) * ((i % 4 == 1) ? 32'hFFFF_FFFF : 32'd1);
      {r.ill, r.res} = ref_alu(r.op, r.a, r.b);
      v.push_back(r);
    end
    run_list("div", v, 33);
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e;
    out_ready = 1'b0;
    issue('{ALU_OPERATOR_DIV, 32'd100, 32'd7, 1'b0, 32'd14});
    wait_out(lat);
    n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL bp_lat: got %0d want 33", lat); end
    e = sb.pop_front();
    in_valid = 1'b1;
    operator = ALU_OPERATOR_ADD;
    operand1 = 32'd1;
    operand2 = 32'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_hs[%0d]: out_valid=%b in_ready=%b want 1/0", i, out_valid, in_ready); end
      n_cmp++; if (result !== e.res) begin n_bad++; $display("FAIL bp_hold_result[%0d]: got %h want %h", i, result, e.res); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_accept[%0d]: out_valid=%b want 0", i, out_valid); end
    end
  endtask

  task automatic test_reset_midop();
    vec_t v[$];
    logic seen;
    issue('{ALU_OPERATOR_DIVU, 32'd1000, 32'd3, 1'b0, 32'd333});
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_idle: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_dropped: out_valid seen=%b want 0", seen); end
    v.push_back('{ALU_OPERATOR_ADD, 32'd2, 32'd3, 1'b0, 32'd5});
    v.push_back('{5'h1F, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 32'h0});
    v.push_back('{ALU_OPERATOR_XOR, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 1'b0, 32'hAAAA_AAAA});
    run_list("post_rst", v, 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    operator  = ALU_OPERATOR_ADD;
    operand1  = '0;
    operand2  = '0;
    test_reset();
    test_simple();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
